// File: rtl/sdram_line_fill_ctrl.sv
// Line-buffer fill controller: each iREQ fetches CHUNK_WORDS words from SDRAM in BURST_LEN
// read bursts and streams them into the line buffer. Define FILL_OVERRUN_CNT_EN to add oOVR_CNT.
module sdram_line_fill_ctrl #(
    parameter int BURST_LEN   = 8,
    parameter int CHUNK_WORDS = 160,
    parameter int FRAME_WORDS = 384000
) (
    input  logic        iRST,
    input  logic        iCLK_W,
    input  logic        iREQ,
    output logic        oREQ_CLR,
    input  logic        iFRAME_START,
    input  logic [22:0] iBASE_ADDR,
    output logic        oRD_REQ,
    output logic [22:0] oRD_ADDR,
    input  logic        iRD_ACK,
    input  logic        iRD_VALID,
    input  logic [15:0] iRD_DATA,
    output logic        oBUF_WE,
    output logic [15:0] oBUF_DATA,
    output logic        oBUSY,
`ifdef FILL_OVERRUN_CNT_EN
    output logic [7:0]  oOVR_CNT,
`endif
    output logic        oOVERRUN
);

    localparam int                CNT_W       = $clog2(CHUNK_WORDS + 1);
    localparam logic [8:0]        BURST_LAST  = 9'(BURST_LEN - 1);
    localparam logic [8:0]        BURST_ONE   = 9'd1;
    localparam logic [CNT_W-1:0]  CHUNK_LAST  = CNT_W'(CHUNK_WORDS - 1);
    localparam logic [CNT_W-1:0]  CHUNK_ONE   = CNT_W'(1);
    localparam logic [22:0]       OFFSET_STEP = 23'(BURST_LEN);
    localparam logic [22:0]       OFFSET_LIM  = 23'(FRAME_WORDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DATA  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [22:0]        offset_q;
    logic [8:0]         burst_cnt_q;
    logic [CNT_W-1:0]   chunk_cnt_q;
    logic               req_prev_q;
    logic               req_clr_q;
    logic               rd_req_q;
    logic               buf_we_q;
    logic [15:0]        buf_data_q;
    logic               busy_q;
    logic               overrun_q;

    logic [22:0]        offset_sum_d;
    logic [22:0]        offset_d;
    logic               ovr_evt_d;

    // Next burst offset, wrapping at the end of the frame
    always_comb begin
        offset_sum_d = offset_q + OFFSET_STEP;
        if (offset_sum_d >= OFFSET_LIM) begin
            offset_d = 23'd0;
        end else begin
            offset_d = offset_sum_d;
        end
    end

    // A fresh request edge while a fill is still running is an overrun
    always_comb begin
        ovr_evt_d = iREQ & ~req_prev_q & busy_q;
    end

    // Fill FSM with all control/data outputs registered
    always_ff @(posedge iCLK_W or posedge iRST) begin
        if (iRST) begin
            state_q     <= S_IDLE;
            offset_q    <= 23'd0;
            burst_cnt_q <= 9'd0;
            chunk_cnt_q <= '0;
            req_prev_q  <= 1'b0;
            req_clr_q   <= 1'b0;
            rd_req_q    <= 1'b0;
            buf_we_q    <= 1'b0;
            buf_data_q  <= 16'h0000;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (iFRAME_START) begin
            state_q     <= S_IDLE;
            offset_q    <= 23'd0;
            burst_cnt_q <= 9'd0;
            chunk_cnt_q <= '0;
            req_prev_q  <= iREQ;
            req_clr_q   <= 1'b0;
            rd_req_q    <= 1'b0;
            buf_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            req_prev_q <= iREQ;
            req_clr_q  <= 1'b0;
            buf_we_q   <= 1'b0;
            if (ovr_evt_d) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    chunk_cnt_q <= '0;
                    if (iREQ) begin
                        state_q   <= S_ISSUE;
                        req_clr_q <= 1'b1;
                        rd_req_q  <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (iRD_ACK) begin
                        state_q     <= S_DATA;
                        rd_req_q    <= 1'b0;
                        burst_cnt_q <= 9'd0;
                        offset_q    <= offset_d;
                    end
                end
                S_DATA: begin
                    if (iRD_VALID) begin
                        buf_we_q    <= 1'b1;
                        buf_data_q  <= iRD_DATA;
                        burst_cnt_q <= burst_cnt_q + BURST_ONE;
                        chunk_cnt_q <= chunk_cnt_q + CHUNK_ONE;
                        if (burst_cnt_q == BURST_LAST) begin
                            if (chunk_cnt_q == CHUNK_LAST) begin
                                state_q <= S_DONE;
                            end else begin
                                state_q  <= S_ISSUE;
                                rd_req_q <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= S_IDLE;
                    rd_req_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef FILL_OVERRUN_CNT_EN
    logic [7:0] ovr_cnt_q;

    // Saturating count of overrun events within the current frame
    always_ff @(posedge iCLK_W or posedge iRST) begin
        if (iRST) begin
            ovr_cnt_q <= 8'd0;
        end else if (iFRAME_START) begin
            ovr_cnt_q <= 8'd0;
        end else if (ovr_evt_d && (ovr_cnt_q != 8'hFF)) begin
            ovr_cnt_q <= ovr_cnt_q + 8'd1;
        end
    end

    assign oOVR_CNT = ovr_cnt_q;
`endif

    // Address is only meaningful while a burst request is pending
    assign oRD_ADDR  = rd_req_q ? (iBASE_ADDR + offset_q) : 23'd0;
    assign oREQ_CLR  = req_clr_q;
    assign oRD_REQ   = rd_req_q;
    assign oBUF_WE   = buf_we_q;
    assign oBUF_DATA = buf_data_q;
    assign oBUSY     = busy_q;
    assign oOVERRUN  = overrun_q;

endmodule
